// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 timing constants, widths and controller state encoding
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W = 10;
  localparam int RGB_W = 12;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if: pixel request, generator colour and pin bundle of the VGA timing controller
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;
  logic en;
  logic [RGB_W-1:0] pix_rgb;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic active;
  logic line_start;
  logic frame_start;
  logic [RGB_W-1:0] rgb;
  logic hs;
  logic vs;
  logic running;
  modport master (
    input en, pix_rgb,
    output x, y, active, line_start, frame_start, rgb, hs, vs, running
  );
  modport slave (
    output en, pix_rgb,
    input x, y, active, line_start, frame_start, rgb, hs, vs, running
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis counter with wrap pulse, active-area and sync-window flags
module vga_axis_counter import vga_timing_pkg::*; #(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP = H_BP
)(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic [CNT_W-1:0] count,
  output logic wrap,
  output logic in_active,
  output logic in_sync
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACTIVE + FP + SYNC + BP - 1);
  localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);
  assign wrap = inc && count == LAST;
  assign in_active = count < ACT_END;
  assign in_sync = count >= SYNC_BEG && count < SYNC_END;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc) count <= wrap ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA h/v timing, run/stop sequencing and latency-matched colour/sync pin stage
module vga_timing_ctrl #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP = vga_timing_pkg::H_FP,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BP = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP = vga_timing_pkg::V_FP,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BP = vga_timing_pkg::V_BP,
  parameter bit SYNC_NEG = 1'b1,
  parameter int PIPE_DLY = 2
)(
  input logic clk,
  input logic rst,
  vga_timing_ctrl_if.master vid
);
  import vga_timing_pkg::*;
  state_t state;
  logic [CNT_W-1:0] hcnt, vcnt;
  logic cnt_en, in_run, h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic [2:0] raw, tap;
  assign cnt_en = state != IDLE;
  assign in_run = state == RUN;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(clk), .rst(rst), .inc(cnt_en), .count(hcnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_sync)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(clk), .rst(rst), .inc(h_wrap), .count(vcnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_sync)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else if (state == IDLE) state <= vid.en ? RUN : IDLE;
    else state <= vid.en ? RUN : v_wrap ? IDLE : STOPPING;
  assign vid.x = hcnt;
  assign vid.y = vcnt;
  assign vid.running = cnt_en;
  assign vid.active = h_act && v_act && in_run;
  assign vid.line_start = hcnt == '0 && v_act && in_run;
  assign vid.frame_start = hcnt == '0 && vcnt == '0 && in_run;
  assign raw = {h_sync, v_sync, vid.active};
  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign tap = raw;
    end else begin : g_dly
      logic [2:0] sr [PIPE_DLY];
      always_ff @(posedge clk) begin
        sr[0] <= rst ? '0 : raw;
        for (int k = 1; k < PIPE_DLY; k++) sr[k] <= rst ? '0 : sr[k-1];
      end
      assign tap = sr[PIPE_DLY-1];
    end
  endgenerate
  always_ff @(posedge clk)
    if (rst) begin
      vid.rgb <= '0;
      vid.hs <= SYNC_NEG;
      vid.vs <= SYNC_NEG;
    end else begin
      vid.rgb <= tap[0] ? vid.pix_rgb : '0;
      vid.hs <= tap[2] ^ SYNC_NEG;
      vid.vs <= tap[1] ^ SYNC_NEG;
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: table vectors plus pin scoreboard for a reduced-geometry controller
module tb_vga_timing_ctrl;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  typedef struct packed { logic [11:0] rgb; logic hs; logic vs; } pin_t;
  typedef struct { int rst, en, n, x, y, run, act, ls, fs; } vec_t;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic en_i = 1'b0;
  logic [11:0] pix_i = '0;
  int checks = 0;
  int errors = 0;
  int m_st = 0, m_h = 0, m_v = 0;
  pin_t sb[$];
  logic [11:0] gq[$];
  vec_t tbl[19];
  always #5 clk = ~clk;
  vga_timing_ctrl_if bus();
  vga_timing_ctrl_if bus0();
  assign bus.en = en_i;
  assign bus.pix_rgb = pix_i;
  assign bus0.en = en_i;
  assign bus0.pix_rgb = pix_i;
  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SYNC_NEG(1'b1), .PIPE_DLY(2)) dut (.clk(clk), .rst(rst_i), .vid(bus));
  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_ACTIVE(VA), .V_FP(VF),
    .V_SYNC(VS), .V_BP(VB), .SYNC_NEG(1'b0), .PIPE_DLY(2)) dut0 (.clk(clk), .rst(rst_i), .vid(bus0));
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [11:0] color(int h, int v);
    return {4'hF, h[3:0], v[3:0]};
  endfunction
  task automatic model_edge();
    bit fe;
    if (rst_i) begin
      m_st = 0;
      m_h = 0;
      m_v = 0;
      sb.delete();
      repeat (3) sb.push_back('0);
    end else begin
      fe = m_st != 0 && m_h == HT - 1 && m_v == VT - 1;
      if (m_st != 0) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          m_v = m_v == VT - 1 ? 0 : m_v + 1;
        end else m_h++;
      end
      m_st = m_st == 0 ? (en_i ? 1 : 0) : en_i ? 1 : fe ? 0 : 2;
    end
  endtask
  task automatic tick();
    pin_t e, n;
    logic act, ls, fs, run_e;
    @(posedge clk);
    model_edge();
    #1;
    run_e = m_st != 0;
    act = m_h < HA && m_v < VA && m_st == 1;
    ls = m_h == 0 && m_v < VA && m_st == 1;
    fs = m_h == 0 && m_v == 0 && m_st == 1;
    check("ctl", {8'b0, bus.x, bus.y, bus.running, bus.active, bus.line_start, bus.frame_start},
      {8'b0, 10'(m_h), 10'(m_v), run_e, act, ls, fs});
    e = sb.pop_front();
    check("pins", {18'b0, bus.rgb, bus.hs, bus.vs}, {18'b0, e.rgb, ~e.hs, ~e.vs});
    check("pins0", {18'b0, bus0.rgb, bus0.hs, bus0.vs}, {18'b0, e.rgb, e.hs, e.vs});
    n.rgb = act ? color(m_h, m_v) : '0;
    n.hs = m_h >= HA + HF && m_h < HA + HF + HS;
    n.vs = m_v >= VA + VF && m_v < VA + VF + VS;
    sb.push_back(n);
    gq.push_back(color(m_h, m_v));
    if (gq.size() > 3) void'(gq.pop_front());
    pix_i = gq[0];
  endtask
  initial begin
    int last_fs, hs_low, hs0_high, vs_low, rgb_nz, run_len;
    logic p_hs, p_vs;
    tbl = '{
      '{1, 0, 3, 0, 0, 0, 0, 0, 0},
      '{0, 1, 1, 0, 0, 1, 1, 1, 1},
      '{0, 1, 1, 1, 0, 1, 1, 0, 0},
      '{0, 1, 23, 24, 0, 1, 0, 0, 0},
      '{0, 1, 1, 0, 1, 1, 1, 1, 0},
      '{0, 1, 16, 16, 1, 1, 0, 0, 0},
      '{0, 1, 109, 0, 6, 1, 0, 0, 0},
      '{0, 1, 175, 0, 0, 1, 1, 1, 1},
      '{0, 0, 1, 1, 0, 1, 0, 0, 0},
      '{0, 0, 323, 24, 12, 1, 0, 0, 0},
      '{0, 0, 1, 0, 0, 0, 0, 0, 0},
      '{0, 0, 5, 0, 0, 0, 0, 0, 0},
      '{0, 1, 1, 0, 0, 1, 1, 1, 1},
      '{0, 0, 50, 0, 2, 1, 0, 0, 0},
      '{0, 1, 1, 1, 2, 1, 1, 0, 0},
      '{0, 1, 274, 0, 0, 1, 1, 1, 1},
      '{0, 1, 222, 22, 8, 1, 0, 0, 0},
      '{1, 1, 1, 0, 0, 0, 0, 0, 0},
      '{0, 1, 1, 0, 0, 1, 1, 1, 1}
    };
    for (int i = 0; i < 19; i++) begin
      rst_i = tbl[i].rst != 0;
      en_i = tbl[i].en != 0;
      if (i == 17) begin
        check("hs_pre_rst", {31'b0, bus.hs}, 0);
        check("vs_pre_rst", {31'b0, bus.vs}, 0);
      end
      repeat (tbl[i].n) tick();
      check($sformatf("row%0d", i),
        {8'b0, bus.x, bus.y, bus.running, bus.active, bus.line_start, bus.frame_start},
        {8'b0, 10'(tbl[i].x), 10'(tbl[i].y), tbl[i].run != 0, tbl[i].act != 0, tbl[i].ls != 0, tbl[i].fs != 0});
      if (i == 17) begin
        check("rst_pins", {18'b0, bus.rgb, bus.hs, bus.vs}, {18'b0, 12'h000, 2'b11});
        check("rst_pins0", {30'b0, bus0.hs, bus0.vs}, 0);
      end
    end
    last_fs = -1;
    hs_low = 0;
    hs0_high = 0;
    vs_low = 0;
    rgb_nz = 0;
    run_len = 0;
    p_hs = bus.hs;
    p_vs = bus.vs;
    for (int c = 1; c <= 2 * HT * VT; c++) begin
      tick();
      if (bus.frame_start) begin
        if (last_fs >= 0) check("fs_period", c - last_fs, HT * VT);
        last_fs = c;
      end
      if (!bus.hs) begin
        hs_low++;
        run_len++;
      end else if (!p_hs) begin
        check("hs_width", run_len, HS);
        run_len = 0;
      end
      if (p_hs && !bus.hs) check("hs_fall_x", {22'b0, bus.x}, HA + HF + 3);
      if (p_vs && !bus.vs) check("vs_fall_xy", {12'b0, bus.x, bus.y}, {12'b0, 10'd3, 10'(VA + VF)});
      if (!bus.vs) vs_low++;
      if (bus0.hs) hs0_high++;
      if (bus.rgb != 12'h000) rgb_nz++;
      p_hs = bus.hs;
      p_vs = bus.vs;
    end
    check("fs_last", last_fs, 2 * HT * VT);
    check("hs_low", hs_low, 2 * VT * HS);
    check("hs0_high", hs0_high, 2 * VT * HS);
    check("vs_low", vs_low, 2 * VS * HT);
    check("rgb_nz", rgb_nz, 2 * HA * VA);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
